keypad_scanner: RTL and testbench

Scans a 4x4 active-low push-button matrix by time-multiplexing the row drives, the input-side counterpart of the board's multiplexed 7-segment display drive. Rows are driven low one at a time and columns are sampled through a synchronizer. Whole-matrix frames are debounced, and a single-key press is reported as one-cycle strobed events carrying a hex key code. Sits between the board pins and the lab datapath; its key codes feed the display path.

---
 rtl/keypad_pkg.sv | 12 +
 rtl/keypad_onehot_enc.sv | 20 ++
 rtl/keypad_scanner.sv | 118 +++++++++++
 tb/tb_keypad_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and FSM encoding for the 4x4 keypad scanner.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    BLOCKED = 2'd2
  } key_state_e;
endpackage

// File: rtl/keypad_onehot_enc.sv
// Classifies the accepted key vector: empty, exactly one key, and lowest set index.
module keypad_onehot_enc
  import keypad_pkg::*;
(
  input  logic [NUM_KEYS-1:0] keys,
  output logic                onehot,
  output logic                zero,
  output logic [3:0]          index
);
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    index  = 4'd0;
    zero   = (keys == '0);
    onehot = !zero && ((keys & (keys - NUM_KEYS'(1))) == '0);
    // Scanning downward leaves the lowest set bit as the final assignment.
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) index = 4'(i);
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// Time-multiplexed 4x4 keypad scanner with frame debounce and single-key event FSM.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_MAX  = 4'(DEBOUNCE);

  logic [3:0]          col_meta, col_sync, col_s;
  logic [DIV_W-1:0]    div;
  logic [1:0]          row;
  logic [NUM_KEYS-1:0] snapshot, frame_snap, prev, accepted, reported;
  logic [3:0]          stable_cnt;
  logic                sample, frame_end;
  logic                acc_onehot, acc_zero, emit;
  logic [3:0]          acc_index;
  key_state_e          state, next_state;

  assign col_s     = ~col_sync;
  assign row_n     = ~(4'b0001 << row);
  assign sample    = (div == DIV_LAST);
  assign frame_end = sample && (row == 2'd3);
  assign reported  = NUM_KEYS'(1) << key_code;
  assign key_down  = (state == HELD);

  // Snapshot with the current row's columns merged in; on frame end this is the full frame.
  always_comb begin
    frame_snap = snapshot;
    frame_snap[{row, 2'b00} +: NUM_COLS] = col_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchronizer resets to "all released" so no phantom press follows reset.
      col_meta   <= 4'hF;
      col_sync   <= 4'hF;
      div        <= '0;
      row        <= 2'd0;
      snapshot   <= '0;
      prev       <= '0;
      accepted   <= '0;
      stable_cnt <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      col_meta <= col_n;
      col_sync <= col_meta;
      if (sample) begin
        div      <= '0;
        row      <= row + 2'd1;
        snapshot <= frame_snap;
      end else begin
        div <= div + DIV_W'(1);
      end
      if (frame_end) begin
        if (frame_snap == prev) begin
          if (stable_cnt < DEB_MAX) begin
            stable_cnt <= stable_cnt + 4'd1;
            if (stable_cnt + 4'd1 == DEB_MAX) accepted <= frame_snap;
          end
        end else begin
          prev       <= frame_snap;
          stable_cnt <= 4'd0;
        end
      end
    end
  end

  keypad_onehot_enc u_enc (
    .keys   (accepted),
    .onehot (acc_onehot),
    .zero   (acc_zero),
    .index  (acc_index)
  );

  always_comb begin
    next_state = state;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        if (acc_onehot) begin
          emit       = 1'b1;
          next_state = HELD;
        end else if (!acc_zero) begin
          next_state = BLOCKED;
        end
      end
      HELD: begin
        if (acc_zero)                    next_state = IDLE;
        else if (accepted != reported)   next_state = BLOCKED;
      end
      BLOCKED: if (acc_zero) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      state     <= next_state;
      key_valid <= emit;
      if (emit) key_code <= acc_index;
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (frame = 16 cycles).
module tb_keypad_scanner;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] pressed = '0;
  int edges = 0;
  int valid_cnt = 0;
  int n_total = 0;
  int n_bad = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk = ~clk;

  // Passive switch matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!row_n[r]) col_n = col_n & ~pressed[r*4 +: 4];
    end
  end

  always @(posedge clk) edges <= rst ? 0 : edges + 1;
  always @(negedge clk) if (key_valid) valid_cnt <= valid_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic to_frame_end();
    do step(1); while (edges % 16 != 0);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!key_valid && n < budget);
  endtask

  task automatic wait_up(input int budget, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (key_down && n < budget);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int v0;

    // Idle sweep and reset values.
    pressed = '0;
    do_reset();
    check("rst_row_n", row_n, 4'b1110);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_down", key_down, 0);
    v0 = valid_cnt;
    for (int e = 0; e < 16; e++) begin
      logic [3:0] exp_row;
      step(1);
      exp_row = ~(4'b0001 << (((e + 1) / 4) % 4));
      check($sformatf("sweep_row_n_%0d", e), row_n, exp_row);
    end
    step(48);
    check("idle_no_valid", valid_cnt - v0, 0);

    // Key 6 held from reset: accepted at the third frame end (edge 48), strobe one edge later.
    pressed = 16'h0040;
    v0 = valid_cnt;
    do_reset();
    wait_valid(200, n);
    check("k6_valid", key_valid, 1);
    check("k6_latency", n, 49);
    check("k6_code", key_code, 6);
    check("k6_down", key_down, 1);
    step(1);
    check("k6_strobe_1cyc", key_valid, 0);
    step(16 * 6);
    check("k6_single_event", valid_cnt - v0, 1);
    check("k6_still_down", key_down, 1);
    to_frame_end();
    pressed = '0;
    wait_up(200, n);
    check("k6_release_down", key_down, 0);
    check("k6_release_lat", n, 49);
    check("k6_code_holds", key_code, 6);

    // Key 15 toggled every frame: never stable long enough.
    pressed = '0;
    do_reset();
    v0 = valid_cnt;
    for (int f = 0; f < 10; f++) begin
      to_frame_end();
      pressed = pressed ^ 16'h8000;
      check($sformatf("toggle_down_%0d", f), key_down, 0);
    end
    step(48);
    check("toggle_no_valid", valid_cnt - v0, 0);
    check("toggle_down_end", key_down, 0);

    // Key 0, then add key 5: blocked, no second event; later key 5 alone reports.
    pressed = 16'h0001;
    do_reset();
    wait_valid(200, n);
    check("k0_valid", key_valid, 1);
    check("k0_latency", n, 49);
    check("k0_code", key_code, 0);
    to_frame_end();
    v0 = valid_cnt;
    pressed = 16'h0021;
    wait_up(200, n);
    check("k0k5_down_fall", key_down, 0);
    check("k0k5_fall_lat", n, 49);
    step(16 * 3);
    check("k0k5_no_event", valid_cnt - v0, 0);
    check("k0k5_code_holds", key_code, 0);
    pressed = '0;
    step(16 * 5);
    pressed = 16'h0020;
    wait_valid(200, n);
    check("k5_valid", key_valid, 1);
    check("k5_code", key_code, 5);
    check("k5_down", key_down, 1);

    // Reset mid-press of key 9, then fresh debounce.
    pressed = 16'h0200;
    do_reset();
    wait_valid(200, n);
    check("k9_valid", key_valid, 1);
    check("k9_code", key_code, 9);
    step(20);
    check("k9_down_pre", key_down, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("k9_rst_row_n", row_n, 4'b1110);
    check("k9_rst_code", key_code, 0);
    check("k9_rst_valid", key_valid, 0);
    check("k9_rst_down", key_down, 0);
    wait_valid(200, n);
    check("k9_re_valid", key_valid, 1);
    check("k9_re_latency", n, 49);
    check("k9_re_code", key_code, 9);

    // Keys 2 and 7 together from idle: blocked; release then key 10 reports.
    pressed = 16'h0084;
    do_reset();
    v0 = valid_cnt;
    step(16 * 6);
    check("k2k7_no_event", valid_cnt - v0, 0);
    check("k2k7_down", key_down, 0);
    pressed = '0;
    step(16 * 5);
    pressed = 16'h0400;
    wait_valid(200, n);
    check("k10_valid", key_valid, 1);
    check("k10_code", key_code, 10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
